// File: rtl/conv3x3_stream_ctrl.sv
// Sequencer for a combinational 3x3 convolution datapath: loads nine weights, streams
// one raster frame through two line buffers and a 3x3 window, returns valid/ready results.
module conv3x3_stream_ctrl #(
    parameter int BW    = 16,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BW-1:0]     w_data,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [BW-1:0]     px_data,
    input  logic              px_valid,
    output logic              px_ready,
    output logic [9*BW-1:0]   dp_in,
    output logic [9*BW-1:0]   dp_w,
    input  logic [BW+3:0]     dp_result,
    output logic [BW+3:0]     out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, LOAD_W, RUN, DONE} state_t;

    state_t             st, nxt;
    logic [8:0][BW-1:0] win, wts;
    logic [3:0]         widx;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic               last_acc;
    logic               fire_q;
    logic [BW-1:0]      lb0 [IMG_W];
    logic [BW-1:0]      lb1 [IMG_W];
    logic               px_acc, w_acc, win_fire, load, last_px;
    logic [BW-1:0]      top, mid;

    assign dp_in = win;
    assign dp_w  = wts;

    always_comb begin
        nxt      = st;
        w_ready  = 1'b0;
        px_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (st)
            IDLE:   if (start) nxt = LOAD_W;
            LOAD_W: begin
                w_ready = 1'b1;
                busy    = 1'b1;
                if (w_valid && widx == 4'd8) nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                // once the last pixel is in, the frame is closed to further pixels
                px_ready = !last_acc && (!out_valid || out_ready);
                if (last_acc && !fire_q && out_valid && out_ready) nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    assign px_acc   = px_valid && px_ready;
    assign w_acc    = w_valid && w_ready;
    assign win_fire = px_acc && (row >= RW'(2)) && (col >= CW'(2));
    assign last_px  = (row == ROW_LAST) && (col == COL_LAST);
    // a pending window result may only move into out_data when the output slot frees up
    assign load     = fire_q && (!out_valid || out_ready);

    // rows 0/1 have nothing above them yet; mask so the window never holds stale RAM data
    assign top = (row >= RW'(2)) ? lb0[col] : '0;
    assign mid = (row >= RW'(1)) ? lb1[col] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            win       <= '0;
            wts       <= '0;
            widx      <= '0;
            col       <= '0;
            row       <= '0;
            last_acc  <= 1'b0;
            fire_q    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            st <= nxt;
            if (st == IDLE && start) begin
                widx     <= '0;
                col      <= '0;
                row      <= '0;
                last_acc <= 1'b0;
                fire_q   <= 1'b0;
            end
            if (w_acc) begin
                wts[widx] <= w_data;
                widx      <= widx + 4'd1;
            end
            if (px_acc) begin
                for (int r = 0; r < 3; r++) begin
                    win[r*3]   <= win[r*3+1];
                    win[r*3+1] <= win[r*3+2];
                end
                win[2] <= top;
                win[5] <= mid;
                win[8] <= px_data;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
                if (last_px) last_acc <= 1'b1;
            end
            fire_q <= win_fire || (fire_q && !load);
            if (load) begin
                out_data  <= dp_result;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // line buffers: lb1 holds the previous row, lb0 the row before that
    always_ff @(posedge clk) begin
        if (px_acc) begin
            lb0[col] <= lb1[col];
            lb1[col] <= px_data;
        end
    end

endmodule
